bram_arbiter: RTL and testbench

Arbitrates the shared RGB frame-buffer BRAM port between the SPI data-transfer path (com, one 8-bit channel per access) and the image-processing engine (pdi, all three channels per access). It uses a registered request/grant handshake with round-robin fairness and bounded hold time under contention. Read data is returned to the requester that issued the read. It sits between `data_transfer_controller`/`img_processing` and the BRAM storage, and replaces the static `pdi_active` mux in `bram_controller`.

---
 rtl/bram_arb_pkg.sv | 17 +
 rtl/rd_tag_pipe.sv | 27 ++
 rtl/bram_arbiter.sv | 88 ++++++++
 tb/tb_bram_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state/owner types, channel constants and lane helpers for bram_arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_COM, S_PDI} state_e;
  typedef enum logic {OWN_COM, OWN_PDI} owner_e;
  localparam logic [1:0] CH_RED = 2'd0, CH_GREEN = 2'd1, CH_BLUE = 2'd2, CH_RSVD = 2'd3;
  typedef struct packed {
    logic   vld;
    owner_e own;
    logic [1:0] ch;
  } tag_t;
  function automatic logic [2:0] lane_mask(input logic [1:0] ch);
    return (ch == CH_RSVD) ? 3'b000 : 3'b001 << ch;
  endfunction
  function automatic logic [7:0] lane_byte(input logic [23:0] w, input logic [1:0] ch);
    return (ch == CH_RED) ? w[7:0] : (ch == CH_GREEN) ? w[15:8] : (ch == CH_BLUE) ? w[23:16] : 8'h00;
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register tracking the owner and channel of each read in flight
module rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld_i,
  input  logic       own_i,
  input  logic [1:0] ch_i,
  output logic       vld_o,
  output logic       own_o,
  output logic [1:0] ch_o
);
  tag_t [RD_LAT-1:0] pipe_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else begin
      pipe_q[0] <= '{vld: vld_i, own: owner_e'(own_i), ch: ch_i};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign vld_o = pipe_q[RD_LAT-1].vld;
  assign own_o = pipe_q[RD_LAT-1].own;
  assign ch_o  = pipe_q[RD_LAT-1].ch;
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin, hold-bounded arbiter sharing one RGB BRAM port between com and pdi
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int MAX_HOLD = 64,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              com_req_i,
  output logic              com_gnt_o,
  input  logic              com_we_i,
  input  logic [ADDR_W-1:0] com_addr_i,
  input  logic [1:0]        com_channel_i,
  input  logic [7:0]        com_wdata_i,
  output logic [7:0]        com_rdata_o,
  output logic              com_rvalid_o,
  input  logic              pdi_req_i,
  output logic              pdi_gnt_o,
  input  logic              pdi_we_i,
  input  logic [ADDR_W-1:0] pdi_addr_i,
  input  logic [23:0]       pdi_wdata_i,
  output logic [23:0]       pdi_rdata_o,
  output logic              pdi_rvalid_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [2:0]        mem_we_o,
  output logic [23:0]       mem_wdata_o,
  input  logic [23:0]       mem_rdata_i
);
  localparam int HW = $clog2(MAX_HOLD);
  state_e state_q, state_d;
  owner_e last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic com_beat, pdi_beat, hold_full, other_req;
  logic t_vld, t_own;
  logic [1:0] t_ch;
  assign com_gnt_o = state_q == S_COM;
  assign pdi_gnt_o = state_q == S_PDI;
  assign com_beat  = com_gnt_o && com_req_i;
  assign pdi_beat  = pdi_gnt_o && pdi_req_i;
  assign hold_full = hold_q == HW'(MAX_HOLD - 1);
  assign other_req = (com_gnt_o && pdi_req_i) || (pdi_gnt_o && com_req_i);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = (com_req_i && pdi_req_i) ? ((last_q == OWN_PDI) ? S_COM : S_PDI)
                       : com_req_i ? S_COM : pdi_req_i ? S_PDI : S_IDLE;
      S_COM:   state_d = !pdi_req_i ? (com_req_i ? S_COM : S_IDLE)
                       : (!com_req_i || hold_full) ? S_PDI : S_COM;
      S_PDI:   state_d = !com_req_i ? (pdi_req_i ? S_PDI : S_IDLE)
                       : (!pdi_req_i || hold_full) ? S_COM : S_PDI;
      default: state_d = S_IDLE;
    endcase
    hold_d = (state_d != state_q) ? '0 : other_req ? hold_q + 1'b1 : hold_q;
    last_d = com_gnt_o ? OWN_COM : pdi_gnt_o ? OWN_PDI : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= OWN_PDI;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
  assign mem_addr_o  = com_beat ? com_addr_i : pdi_beat ? pdi_addr_i : '0;
  assign mem_wdata_o = com_beat ? {3{com_wdata_i}} : pdi_beat ? pdi_wdata_i : '0;
  assign mem_we_o    = (com_beat && com_we_i) ? lane_mask(com_channel_i)
                     : (pdi_beat && pdi_we_i) ? 3'b111 : 3'b000;
  // tags follow each read so data lands with its issuer even across grant switches
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i ((com_beat && !com_we_i) || (pdi_beat && !pdi_we_i)),
    .own_i (!com_beat),
    .ch_i  (com_channel_i),
    .vld_o (t_vld),
    .own_o (t_own),
    .ch_o  (t_ch)
  );
  assign com_rvalid_o = t_vld && !t_own;
  assign pdi_rvalid_o = t_vld && t_own;
  assign com_rdata_o  = com_rvalid_o ? lane_byte(mem_rdata_i, t_ch) : '0;
  assign pdi_rdata_o  = pdi_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: scoreboard bench with a shadow-memory reference model and a latency-accurate BRAM
module tb_bram_arbiter;
  localparam int AW = 17, MH = 4, RL = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic com_req, com_gnt, com_we, com_rvalid;
  logic [AW-1:0] com_addr, pdi_addr, mem_addr;
  logic [1:0] com_ch;
  logic [7:0] com_wdata, com_rdata;
  logic pdi_req, pdi_gnt, pdi_we, pdi_rvalid;
  logic [23:0] pdi_wdata, pdi_rdata, mem_wdata, mem_rdata;
  logic [2:0] mem_we;
  typedef struct {int due; logic [23:0] d;} exp_t;
  exp_t com_q[$], pdi_q[$];
  logic [23:0] shadow [256] = '{default: '0};
  logic [23:0] bram [256] = '{default: '0};
  logic [23:0] rpipe [RL] = '{default: '0};
  int cnt = 0, tests = 0, fails = 0, com_wait = 0, pdi_wait = 0;
  always #5 clk = ~clk;
  bram_arbiter #(.ADDR_W(AW), .MAX_HOLD(MH), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .com_req_i(com_req), .com_gnt_o(com_gnt), .com_we_i(com_we), .com_addr_i(com_addr),
    .com_channel_i(com_ch), .com_wdata_i(com_wdata), .com_rdata_o(com_rdata), .com_rvalid_o(com_rvalid),
    .pdi_req_i(pdi_req), .pdi_gnt_o(pdi_gnt), .pdi_we_i(pdi_we), .pdi_addr_i(pdi_addr),
    .pdi_wdata_i(pdi_wdata), .pdi_rdata_o(pdi_rdata), .pdi_rvalid_o(pdi_rvalid),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  // BRAM with RL cycles of read latency and per-lane write enables
  always @(posedge clk) begin
    logic [23:0] m;
    m = {{8{mem_we[2]}}, {8{mem_we[1]}}, {8{mem_we[0]}}};
    if (|mem_we) bram[mem_addr[7:0]] <= (bram[mem_addr[7:0]] & ~m) | (mem_wdata & m);
    rpipe[0] <= bram[mem_addr[7:0]];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    cnt <= cnt + 1;
  end
  assign mem_rdata = rpipe[RL-1];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, got, exp, $time);
    end
  endtask
  // monitor: pop expected read results whenever the DUT presents one
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("grant_mutex", {31'b0, com_gnt && pdi_gnt}, 32'd0);
      if (com_rvalid) begin
        if (com_q.size() == 0) chk("com_rvalid_spurious", 32'd1, 32'd0);
        else begin
          e = com_q.pop_front();
          chk("com_rdata", {24'b0, com_rdata}, {8'b0, e.d});
          chk("com_rlat", cnt, e.due);
        end
      end else if (com_q.size() != 0 && com_q[0].due <= cnt) begin
        e = com_q.pop_front();
        chk("com_rvalid_missing", 32'd0, 32'd1);
      end
      if (pdi_rvalid) begin
        if (pdi_q.size() == 0) chk("pdi_rvalid_spurious", 32'd1, 32'd0);
        else begin
          e = pdi_q.pop_front();
          chk("pdi_rdata", {8'b0, pdi_rdata}, {8'b0, e.d});
          chk("pdi_rlat", cnt, e.due);
        end
      end else if (pdi_q.size() != 0 && pdi_q[0].due <= cnt) begin
        e = pdi_q.pop_front();
        chk("pdi_rvalid_missing", 32'd0, 32'd1);
      end
    end
  end
  // reference model: a beat is gnt && req; reads expect the shadow word, writes update it
  task automatic step();
    if (com_req && com_gnt) begin
      if (!com_we)
        com_q.push_back('{cnt + RL, (com_ch == 2'd3) ? 24'h0 : {16'h0, shadow[com_addr[7:0]][int'(com_ch)*8 +: 8]}});
      else if (com_ch != 2'd3) shadow[com_addr[7:0]][int'(com_ch)*8 +: 8] = com_wdata;
    end
    if (pdi_req && pdi_gnt) begin
      if (!pdi_we) pdi_q.push_back('{cnt + RL, shadow[pdi_addr[7:0]]});
      else shadow[pdi_addr[7:0]] = pdi_wdata;
    end
    if (com_req && !com_gnt) com_wait++;
    else begin
      if (com_req && com_wait > 0) chk("com_wait_bound", {31'b0, com_wait <= MH + 1}, 32'd1);
      com_wait = 0;
    end
    if (pdi_req && !pdi_gnt) pdi_wait++;
    else begin
      if (pdi_req && pdi_wait > 0) chk("pdi_wait_bound", {31'b0, pdi_wait <= MH + 1}, 32'd1);
      pdi_wait = 0;
    end
    @(negedge clk);
  endtask
  task automatic chk_gnt(input string n, input logic c, input logic p);
    chk({n, "_com_gnt"}, {31'b0, com_gnt}, {31'b0, c});
    chk({n, "_pdi_gnt"}, {31'b0, pdi_gnt}, {31'b0, p});
  endtask
  initial begin
    logic exp_c;
    {com_req, com_we, com_addr, com_ch, com_wdata} = '0;
    {pdi_req, pdi_we, pdi_addr, pdi_wdata} = '0;
    repeat (2) @(negedge clk);
    chk_gnt("reset", 1'b0, 1'b0);
    chk("reset_rvalid", {30'b0, com_rvalid, pdi_rvalid}, 32'd0);
    chk("reset_rdata", {com_rdata, pdi_rdata}, 32'd0);
    chk("reset_mem_we", {29'b0, mem_we}, 32'd0);
    rst_n = 1'b1;
    // first tie after reset goes to com; com write/read and reserved channel
    com_req = 1; pdi_req = 1; com_we = 1; com_ch = 2'd1; com_addr = 17'h10; com_wdata = 8'hA5;
    step();
    chk_gnt("tie_after_reset", 1'b1, 1'b0);
    chk("com_wr_we", {29'b0, mem_we}, 32'b010);
    chk("com_wr_data", {8'b0, mem_wdata}, 32'hA5A5A5);
    chk("com_wr_addr", {15'b0, mem_addr}, 32'h10);
    step();
    com_we = 0; step();
    com_ch = 2'd3; step();
    com_we = 1; com_wdata = 8'hFF; #1;
    chk("com_rsvd_wr_we", {29'b0, mem_we}, 32'd0);
    step();
    chk_gnt("preempt", 1'b0, 1'b1);
    // pdi write then 8 back-to-back reads
    com_req = 0;
    for (int j = 0; j < 8; j++) begin
      pdi_we = 1; pdi_addr = AW'(32 + j); pdi_wdata = 24'($urandom); step();
    end
    for (int j = 0; j < 8; j++) begin
      pdi_we = 0; pdi_addr = AW'(32 + j); step();
    end
    pdi_req = 0;
    repeat (RL + 2) step();
    // contention: windows of MH cycles alternate, reads cross the switch
    com_we = 0; pdi_we = 0; com_req = 1; pdi_req = 1;
    step();
    for (int i = 1; i <= 16; i++) begin
      exp_c = ((i - 1) / MH) % 2 == 0;
      chk_gnt("contention", exp_c, !exp_c);
      com_addr = AW'($urandom_range(0, 63)); com_ch = 2'($urandom_range(0, 3));
      pdi_addr = AW'($urandom_range(0, 63));
      step();
    end
    com_req = 0; pdi_req = 0;
    repeat (RL + 2) step();
    // direct switches with no idle cycle between grants
    pdi_req = 1; step();
    chk_gnt("single_req", 1'b0, 1'b1);
    com_req = 1; pdi_req = 0; step();
    chk_gnt("switch_to_com", 1'b1, 1'b0);
    com_req = 0; pdi_req = 1; step();
    chk_gnt("switch_to_pdi", 1'b0, 1'b1);
    pdi_req = 0;
    repeat (RL + 2) step();
    // randomized traffic; requesters only release after being granted
    for (int n = 0; n < 400; n++) begin
      if (!com_req) com_req = $urandom_range(0, 3) == 0;
      else if (com_gnt && $urandom_range(0, 5) == 0) com_req = 0;
      if (!pdi_req) pdi_req = $urandom_range(0, 3) == 0;
      else if (pdi_gnt && $urandom_range(0, 5) == 0) pdi_req = 0;
      com_we = 1'($urandom); com_ch = 2'($urandom); com_addr = AW'($urandom_range(0, 63));
      com_wdata = 8'($urandom);
      pdi_we = 1'($urandom); pdi_addr = AW'($urandom_range(0, 63)); pdi_wdata = 24'($urandom);
      step();
    end
    com_req = 0; pdi_req = 0;
    repeat (RL + 2) step();
    // reset in the middle of a pdi burst drops everything in flight
    pdi_req = 1;
    for (int j = 0; j < 6; j++) begin
      pdi_we = j[0]; pdi_addr = AW'(40 + j); pdi_wdata = 24'($urandom); step();
    end
    pdi_we = 1; #1;
    chk("burst_mem_we", {29'b0, mem_we}, 32'b111);
    rst_n = 0; #1;
    chk_gnt("mid_reset", 1'b0, 1'b0);
    chk("mid_reset_rvalid", {30'b0, com_rvalid, pdi_rvalid}, 32'd0);
    chk("mid_reset_mem_we", {29'b0, mem_we}, 32'd0);
    chk("mid_reset_rdata", {8'b0, pdi_rdata}, 32'd0);
    com_q.delete(); pdi_q.delete();
    pdi_req = 0; pdi_we = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (RL + 2) begin
      step();
      chk("post_reset_rvalid", {30'b0, com_rvalid, pdi_rvalid}, 32'd0);
    end
    com_req = 1; pdi_req = 1; com_we = 0;
    step();
    chk_gnt("tie_after_mid_reset", 1'b1, 1'b0);
    com_req = 0; pdi_req = 0;
    repeat (RL + 2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
